gaussian_stream_filter: RTL

- Streaming, pipelined successor to the combinational 3x3 Gaussian block.
- Accepts one grey pixel per valid cycle in raster order and builds the 3x3 window internally from two line buffers.
- Emits the 1-2-1 / 2-4-2 / 1-2-1 weighted result (sum/16) for interior pixels, with a runtime-selectable mode.
- Sits between the grey-conversion stage and the edge/stylisation stages of the video path.

---
 rtl/gauss_pkg.sv | 20 ++
 rtl/gauss_line_buffer.sv | 24 ++
 rtl/gaussian_stream_filter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// Shared constants for the streaming 3x3 Gaussian filter: mode encodings,
// kernel weights (as shift amounts) and the normalisation / rounding constants.
package gauss_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_TRUNC  = 2'd1,
      MODE_ROUND  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   // 1-2-1 / 2-4-2 / 1-2-1: every weight is a power of two, so store log2.
   localparam int unsigned KERNEL_SHL [3][3] = '{'{0, 1, 0},
                                                 '{1, 2, 1},
                                                 '{0, 1, 0}};

   localparam int unsigned SUM_SHIFT  = 4;
   localparam int unsigned ROUND_BIAS = 8;

endpackage

// File: rtl/gauss_line_buffer.sv
// One-line delay for the window builder: returns the pixel written IMG_W accepts ago
// at the same column. Combinational read of old data, write on enable; no backpressure.
module gauss_line_buffer #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wr_dat_i,
   output logic [DATA_W-1:0] rd_dat_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Addressed by column so an iSOF resync realigns the delay line with the frame.
   assign rd_dat_o = mem_q[addr_i];

   always_ff @(posedge clk_i) begin
      if (en_i) mem_q[addr_i] <= wr_dat_i;
   end

endmodule

// File: rtl/gaussian_stream_filter.sv
// Streaming 3x3 Gaussian (valid-convolution only); output registered one edge after the
// window update. No backpressure: every iDVAL pixel is consumed, idle cycles freeze state.
module gaussian_stream_filter
   import gauss_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iDVAL,
   input  logic              iSOF,
   input  logic [DATA_W-1:0] iData,
   input  logic [1:0]        iMode,
   output logic              oDVAL,
   output logic [DATA_W-1:0] oData,
   output logic              oFrameDone
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int SW = DATA_W + 4;

   logic [1:0]        rst_sync_q;
   logic              rst_n;
   logic [XW-1:0]     x_q, x_d, px_x;
   logic [YW-1:0]     y_q, y_d, px_y;
   mode_e             mode_q, mode_d;
   logic [DATA_W-1:0] win_q [3][3];
   logic [DATA_W-1:0] win_d [3][3];
   logic [DATA_W-1:0] lb0_dat, lb1_dat;
   logic              vld_q, vld_d, last_q, last_d;
   logic              odval_q, ofd_q;
   logic [DATA_W-1:0] odata_q, odata_d, filt;
   logic [SW-1:0]     sum, sum_rnd;

   // Asynchronous assertion, release synchronised to iCLK.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) rst_sync_q <= '0;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   gauss_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(XW)) u_lb0 (
      .clk_i(iCLK), .en_i(iDVAL), .addr_i(px_x), .wr_dat_i(iData), .rd_dat_o(lb0_dat)
   );
   gauss_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(XW)) u_lb1 (
      .clk_i(iCLK), .en_i(iDVAL), .addr_i(px_x), .wr_dat_i(lb0_dat), .rd_dat_o(lb1_dat)
   );

   always_comb begin
      px_x   = iSOF ? '0 : x_q;
      px_y   = iSOF ? '0 : y_q;
      x_d    = x_q;
      y_d    = y_q;
      mode_d = mode_q;
      win_d  = win_q;
      vld_d  = 1'b0;
      last_d = 1'b0;
      if (iDVAL) begin
         if (px_x == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (px_y == YW'(IMG_H - 1)) ? '0 : px_y + 1'b1;
         end else begin
            x_d = px_x + 1'b1;
            y_d = px_y;
         end
         if (px_x == '0 && px_y == '0) mode_d = mode_e'(iMode);
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_dat;
         win_d[1][2] = lb0_dat;
         win_d[2][2] = iData;
         vld_d  = (px_x >= XW'(2)) && (px_y >= YW'(2));
         last_d = (px_x == XW'(IMG_W - 1)) && (px_y == YW'(IMG_H - 1));
      end
   end

   always_comb begin
      sum = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            sum = sum + (SW'(win_q[r][c]) << KERNEL_SHL[r][c]);
         end
      end
      sum_rnd = sum + SW'(ROUND_BIAS);
      case (mode_q)
         MODE_TRUNC: filt = DATA_W'(sum >> SUM_SHIFT);
         MODE_ROUND: filt = DATA_W'(sum_rnd >> SUM_SHIFT);
         default:    filt = win_q[1][1];
      endcase
      odata_d = vld_q ? filt : odata_q;
   end

   always_ff @(posedge iCLK or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         mode_q  <= MODE_BYPASS;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         odval_q <= 1'b0;
         ofd_q   <= 1'b0;
         odata_q <= '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
         end
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         mode_q  <= mode_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         odval_q <= vld_q;
         ofd_q   <= last_q;
         odata_q <= odata_d;
         win_q   <= win_d;
      end
   end

   assign oDVAL      = odval_q;
   assign oData      = odata_q;
   assign oFrameDone = ofd_q;

endmodule
